// File: rtl/ghost_mode_sequencer_pkg.sv
// rtl/ghost_mode_sequencer_pkg.sv - shared mode encodings, scatter/chase schedule and direction codes
package ghost_mode_sequencer_pkg;

    typedef enum logic [1:0] {
        MODE_SCATTER = 2'd0,
        MODE_CHASE   = 2'd1,
        MODE_FRIGHT  = 2'd2
    } mode_t;

    // Direction codes shared with the ghost AI blocks.
    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_DOWN  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    localparam logic [4:0] SCHED0 = 5'd7;
    localparam logic [4:0] SCHED1 = 5'd20;
    localparam logic [4:0] SCHED2 = 5'd7;
    localparam logic [4:0] SCHED3 = 5'd20;
    localparam logic [4:0] SCHED4 = 5'd5;
    localparam logic [4:0] SCHED5 = 5'd20;
    localparam logic [4:0] SCHED6 = 5'd5;

    localparam logic [2:0] LAST_PHASE = 3'd7;

    // Phase 7 never expires, so its length is unused.
    function automatic logic [4:0] schedSecs(input logic [2:0] idx);
        case (idx)
            3'd0:    schedSecs = SCHED0;
            3'd1:    schedSecs = SCHED1;
            3'd2:    schedSecs = SCHED2;
            3'd3:    schedSecs = SCHED3;
            3'd4:    schedSecs = SCHED4;
            3'd5:    schedSecs = SCHED5;
            3'd6:    schedSecs = SCHED6;
            default: schedSecs = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ghost_mode_sequencer_sec_prescaler.sv
// rtl/ghost_mode_sequencer_sec_prescaler.sv - sec_prescaler: TICK_DIV clock divider producing a one-cycle secTick
module sec_prescaler #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic hold,
    output logic secTick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;
    logic          run;

    assign run     = enable && !hold;
    assign secTick = run && (count == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (run) begin
            count <= (count == LAST) ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/ghost_mode_sequencer.sv
// rtl/ghost_mode_sequencer.sv - scatter/chase scheduler with frightened overlay; optional GHOST_MODE_FREEZE_EN adds eat_freeze
module ghost_mode_sequencer
    import ghost_mode_sequencer_pkg::*;
#(
    parameter int TICK_DIV    = 25_000_000,
    parameter int FRIGHT_SECS = 6,
    parameter int FLASH_SECS  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       pellet_eaten,
    input  logic       ghost_eaten,
`ifdef GHOST_MODE_FREEZE_EN
    input  logic       eat_freeze,
`endif
    output logic [1:0] mode,
    output logic [2:0] phase_idx,
    output logic       reverse_pulse,
    output logic       flash,
    output logic       eat_valid,
    output logic [1:0] eat_idx
);

    localparam logic [7:0] FRIGHT_LOAD = 8'(FRIGHT_SECS);
    localparam logic [7:0] FLASH_LIM   = 8'(FLASH_SECS);
    localparam logic       FLASH_AT_LOAD = (FRIGHT_LOAD <= FLASH_LIM);

    logic       secTick;
    logic       hold;
    mode_t      modeQ;
    mode_t      baseMode;
    logic [2:0] phaseIdx;
    logic [4:0] phaseRem;
    logic [7:0] frightRem;
    logic [7:0] frightDec;
    logic [1:0] combo;

`ifdef GHOST_MODE_FREEZE_EN
    assign hold = eat_freeze;
`else
    assign hold = 1'b0;
`endif

    sec_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .hold    (hold),
        .secTick (secTick)
    );

    assign frightDec = frightRem - 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            modeQ         <= MODE_SCATTER;
            baseMode      <= MODE_SCATTER;
            phaseIdx      <= 3'd0;
            phaseRem      <= SCHED0;
            frightRem     <= 8'd0;
            combo         <= 2'd0;
            reverse_pulse <= 1'b0;
            flash         <= 1'b0;
            eat_valid     <= 1'b0;
            eat_idx       <= 2'd0;
        end else begin
            reverse_pulse <= 1'b0;
            eat_valid     <= 1'b0;
            if (enable) begin
                // Scored before any pellet handling so a same-cycle pellet sees the old combo.
                if (ghost_eaten && modeQ == MODE_FRIGHT) begin
                    eat_valid <= 1'b1;
                    eat_idx   <= combo;
                    combo     <= (combo == 2'd3) ? 2'd3 : combo + 2'd1;
                end
                if (pellet_eaten) begin
                    if (modeQ != MODE_FRIGHT) begin
                        baseMode <= modeQ;
                    end
                    modeQ         <= MODE_FRIGHT;
                    frightRem     <= FRIGHT_LOAD;
                    combo         <= 2'd0;
                    reverse_pulse <= 1'b1;
                    flash         <= FLASH_AT_LOAD;
                end else if (modeQ == MODE_FRIGHT) begin
                    if (secTick) begin
                        if (frightRem == 8'd1) begin
                            modeQ     <= baseMode;
                            frightRem <= 8'd0;
                            flash     <= 1'b0;
                        end else begin
                            frightRem <= frightDec;
                            flash     <= (frightDec <= FLASH_LIM);
                        end
                    end
                end else if (secTick && phaseIdx != LAST_PHASE) begin
                    if (phaseRem == 5'd1) begin
                        phaseIdx      <= phaseIdx + 3'd1;
                        phaseRem      <= schedSecs(phaseIdx + 3'd1);
                        modeQ         <= (modeQ == MODE_SCATTER) ? MODE_CHASE : MODE_SCATTER;
                        reverse_pulse <= 1'b1;
                    end else begin
                        phaseRem <= phaseRem - 5'd1;
                    end
                end
            end
        end
    end

    assign mode      = modeQ;
    assign phase_idx = phaseIdx;

endmodule

// File: tb/tb_ghost_mode_sequencer.sv
// tb/tb_ghost_mode_sequencer.sv - directed plus random self-checking bench for ghost_mode_sequencer
module tb_ghost_mode_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       pellet_eaten = 1'b0;
    logic       ghost_eaten = 1'b0;
    logic [1:0] mode;
    logic [2:0] phase_idx;
    logic       reverse_pulse;
    logic       flash;
    logic       eat_valid;
    logic [1:0] eat_idx;

    always #5 clk = ~clk;

    ghost_mode_sequencer #(.TICK_DIV(4), .FRIGHT_SECS(6), .FLASH_SECS(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .pellet_eaten  (pellet_eaten),
        .ghost_eaten   (ghost_eaten),
        .mode          (mode),
        .phase_idx     (phase_idx),
        .reverse_pulse (reverse_pulse),
        .flash         (flash),
        .eat_valid     (eat_valid),
        .eat_idx       (eat_idx)
    );

    int total = 0;
    int bad = 0;

    // Reference: schedule time elapsed outside FRIGHT, and cumulative phase boundaries in seconds.
    int cum[7] = '{7, 27, 34, 54, 59, 79, 84};
    int presc, elapsed, frightLeft, combo;
    int eMode, ePhase, eRev, eFlash, eEv, eEi;
    int revCount;
    int eatLog[$];

    function automatic int phaseOf(input int e);
        int p = 0;
        for (int i = 0; i < 7; i++) if (e >= cum[i]) p++;
        return p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic model(input logic r, input logic e, input logic p, input logic g);
        bit tick;
        int oldPhase;
        eRev = 0;
        eEv = 0;
        if (r) begin
            presc = 0; elapsed = 0; frightLeft = 0; combo = 0; eEi = 0;
        end else if (e) begin
            tick = (presc == 3);
            presc = (presc + 1) % 4;
            if (g && frightLeft > 0) begin
                eEv = 1;
                eEi = combo;
                if (combo < 3) combo++;
            end
            if (p) begin
                frightLeft = 6;
                combo = 0;
                eRev = 1;
            end else if (frightLeft > 0) begin
                if (tick) frightLeft--;
            end else if (tick && elapsed < cum[6]) begin
                oldPhase = phaseOf(elapsed);
                elapsed++;
                if (phaseOf(elapsed) != oldPhase) eRev = 1;
            end
        end
        ePhase = phaseOf(elapsed);
        eMode = (frightLeft > 0) ? 2 : (ePhase % 2);
        eFlash = (frightLeft > 0 && frightLeft <= 2) ? 1 : 0;
    endtask

    task automatic cyc(input logic r, input logic e, input logic p, input logic g);
        reset = r; enable = e; pellet_eaten = p; ghost_eaten = g;
        @(posedge clk);
        #1;
        model(r, e, p, g);
        chk("mode", 32'(mode), 32'(eMode));
        chk("phase_idx", 32'(phase_idx), 32'(ePhase));
        chk("reverse_pulse", 32'(reverse_pulse), 32'(eRev));
        chk("flash", 32'(flash), 32'(eFlash));
        chk("eat_valid", 32'(eat_valid), 32'(eEv));
        if (eEv != 0) chk("eat_idx", 32'(eat_idx), 32'(eEi));
        if (reverse_pulse === 1'b1) revCount++;
        if (eat_valid === 1'b1) eatLog.push_back(int'(eat_idx));
    endtask

    initial begin
        // Reset state and the first 28 seconds of schedule.
        repeat (2) cyc(1, 0, 0, 0);
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_phase", 32'(phase_idx), 32'd0);
        revCount = 0;
        repeat (112) cyc(0, 1, 0, 0);
        chk("rev_count_28s", 32'(revCount), 32'd2);

        // Pellet 3 s into phase 0, five ghost eats, then expiry back to SCATTER.
        repeat (2) cyc(1, 0, 0, 0);
        repeat (12) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        chk("pellet_mode", 32'(mode), 32'd2);
        chk("pellet_reverse", 32'(reverse_pulse), 32'd1);
        eatLog.delete();
        for (int i = 0; i < 5; i++) begin
            cyc(0, 1, 0, 1);
            cyc(0, 1, 0, 0);
        end
        chk("eat_count", 32'(eatLog.size()), 32'd5);
        if (eatLog.size() == 5) begin
            chk("eat_seq0", 32'(eatLog[0]), 32'd0);
            chk("eat_seq1", 32'(eatLog[1]), 32'd1);
            chk("eat_seq2", 32'(eatLog[2]), 32'd2);
            chk("eat_seq3", 32'(eatLog[3]), 32'd3);
            chk("eat_seq4", 32'(eatLog[4]), 32'd3);
        end
        repeat (20) cyc(0, 1, 0, 0);
        chk("fright_over_mode", 32'(mode), 32'd0);
        cyc(0, 1, 0, 1);
        chk("eat_outside", 32'(eat_valid), 32'd0);

        // Second pellet 4 s into FRIGHT reloads the timer and drops flash.
        cyc(0, 1, 1, 0);
        repeat (16) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 1);
        chk("reload_flash", 32'(flash), 32'd0);
        repeat (30) cyc(0, 1, 0, 0);

        // Pellet on the same cycle as the phase-0 expiry tick.
        repeat (2) cyc(1, 0, 0, 0);
        repeat (27) cyc(0, 1, 0, 0);
        cyc(0, 1, 1, 0);
        chk("clash_mode", 32'(mode), 32'd2);
        chk("clash_phase", 32'(phase_idx), 32'd0);
        repeat (30) cyc(0, 1, 0, 0);

        // Enable low for 10 ticks mid-CHASE.
        repeat (2) cyc(1, 0, 0, 0);
        repeat (40) cyc(0, 1, 0, 0);
        revCount = 0;
        for (int i = 0; i < 40; i++) cyc(0, 0, (i % 7) == 3, (i % 5) == 1);
        chk("disabled_pulses", 32'(revCount), 32'd0);
        repeat (80) cyc(0, 1, 0, 0);

        // Reset mid-FRIGHT.
        cyc(0, 1, 1, 0);
        repeat (5) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("reset_fright_mode", 32'(mode), 32'd0);
        chk("reset_fright_flash", 32'(flash), 32'd0);

        // Run to the final, non-expiring CHASE phase.
        repeat (400) cyc(0, 1, 0, 0);
        chk("final_phase", 32'(phase_idx), 32'd7);

        // Random traffic.
        for (int i = 0; i < 4000; i++)
            cyc(($urandom_range(0, 1499) == 0), ($urandom_range(0, 9) != 0),
                ($urandom_range(0, 59) == 0), ($urandom_range(0, 9) == 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
